// File: rtl/riscv_instr_aligner_if.sv
// Fetch-side and decode-side handshake bundle for the instruction aligner.
// A transfer happens on a rising edge where valid && ready; a producer holding valid high keeps its payload until then.
interface riscv_instr_aligner_if;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic [31:0] fetch_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_compressed;

    modport master (
        output flush, flush_pc, fetch_valid, fetch_data, fetch_pc, out_ready,
        input  fetch_ready, out_valid, out_instr, out_pc, out_compressed
    );

    modport slave (
        input  flush, flush_pc, fetch_valid, fetch_data, fetch_pc, out_ready,
        output fetch_ready, out_valid, out_instr, out_pc, out_compressed
    );
endinterface

// File: rtl/riscv_instr_aligner.sv
// Splits 32-bit fetch words into 16/32-bit RISC-V instructions, carrying a leftover halfword
// between words so instructions that straddle a word boundary are reassembled.
module riscv_instr_aligner (
    input  logic                         clk,
    input  logic                         rst,
    riscv_instr_aligner_if.slave         bus,
    output logic [1:0]                   o_dbg_state
);

    // S_SKIP: redirect landed on an upper halfword, so the next word's low parcel is dropped.
    // S_RES:  a residual halfword is held in r_res_h.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_SKIP  = 2'd1,
        S_RES   = 2'd2
    } state_t;

    state_t      r_state,     w_state_nxt;
    logic [15:0] r_res_h,     w_res_h_nxt;
    logic [31:0] r_res_pc,    w_res_pc_nxt;
    logic        r_out_valid, w_out_valid_nxt;
    logic [31:0] r_out_instr, w_out_instr_nxt;
    logic [31:0] r_out_pc,    w_out_pc_nxt;
    logic        r_out_comp,  w_out_comp_nxt;

    logic w_load;
    logic w_res_comp;
    logic w_fetch_ready;
    logic w_hs;
    logic w_unused_flush_pc;

    assign w_load        = !r_out_valid || bus.out_ready;
    assign w_res_comp    = (r_state == S_RES) && (r_res_h[1:0] != 2'b11);
    assign w_fetch_ready = w_load && !bus.flush && !w_res_comp;
    assign w_hs          = bus.fetch_valid && w_fetch_ready;

    assign w_unused_flush_pc = ^{bus.flush_pc[31:2], bus.flush_pc[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_res_h     <= 16'h0;
            r_res_pc    <= 32'h0;
            r_out_valid <= 1'b0;
            r_out_instr <= 32'h0;
            r_out_pc    <= 32'h0;
            r_out_comp  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_res_h     <= w_res_h_nxt;
            r_res_pc    <= w_res_pc_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_instr <= w_out_instr_nxt;
            r_out_pc    <= w_out_pc_nxt;
            r_out_comp  <= w_out_comp_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_res_h_nxt     = r_res_h;
        w_res_pc_nxt    = r_res_pc;
        w_out_valid_nxt = r_out_valid;
        w_out_instr_nxt = r_out_instr;
        w_out_pc_nxt    = r_out_pc;
        w_out_comp_nxt  = r_out_comp;

        if (bus.flush) begin
            w_state_nxt     = bus.flush_pc[1] ? S_SKIP : S_EMPTY;
            w_out_valid_nxt = 1'b0;
        end else if (w_load) begin
            w_out_valid_nxt = 1'b0;
            case (r_state)
                S_RES: begin
                    if (w_res_comp) begin
                        w_out_valid_nxt = 1'b1;
                        w_out_instr_nxt = {16'h0, r_res_h};
                        w_out_pc_nxt    = r_res_pc;
                        w_out_comp_nxt  = 1'b1;
                        w_state_nxt     = S_EMPTY;
                    end else if (w_hs) begin
                        w_out_valid_nxt = 1'b1;
                        w_out_instr_nxt = {bus.fetch_data[15:0], r_res_h};
                        w_out_pc_nxt    = r_res_pc;
                        w_out_comp_nxt  = 1'b0;
                        w_res_h_nxt     = bus.fetch_data[31:16];
                        w_res_pc_nxt    = bus.fetch_pc + 32'd2;
                    end
                end
                S_SKIP: begin
                    if (w_hs) begin
                        w_res_h_nxt  = bus.fetch_data[31:16];
                        w_res_pc_nxt = bus.fetch_pc + 32'd2;
                        w_state_nxt  = S_RES;
                    end
                end
                default: begin
                    if (w_hs) begin
                        w_out_valid_nxt = 1'b1;
                        w_out_pc_nxt    = bus.fetch_pc;
                        if (bus.fetch_data[1:0] != 2'b11) begin
                            w_out_instr_nxt = {16'h0, bus.fetch_data[15:0]};
                            w_out_comp_nxt  = 1'b1;
                            w_res_h_nxt     = bus.fetch_data[31:16];
                            w_res_pc_nxt    = bus.fetch_pc + 32'd2;
                            w_state_nxt     = S_RES;
                        end else begin
                            w_out_instr_nxt = bus.fetch_data;
                            w_out_comp_nxt  = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.fetch_ready    = w_fetch_ready;
    assign bus.out_valid      = r_out_valid;
    assign bus.out_instr      = r_out_instr;
    assign bus.out_pc         = r_out_pc;
    assign bus.out_compressed = r_out_comp;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_riscv_instr_aligner.sv
// Bench for riscv_instr_aligner: directed scenarios followed by random traffic, all checked
// against a halfword-stream reference model.
module tb_riscv_instr_aligner;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    riscv_instr_aligner_if bus_if();

    riscv_instr_aligner dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected instructions {compressed, pc, instr} and pending halfwords {pc, parcel}.
    logic [64:0] exp_q[$];
    logic [47:0] hq[$];
    logic        m_skip;
    logic        prev_stall;
    logic        prev_flush;
    logic [64:0] held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] instr,
                           input logic [31:0] pc, input logic c);
        chk({tag, "_valid"}, {31'b0, bus_if.out_valid}, {31'b0, v});
        if (v) begin
            chk({tag, "_instr"}, bus_if.out_instr, instr);
            chk({tag, "_pc"},    bus_if.out_pc,    pc);
            chk({tag, "_c"},     {31'b0, bus_if.out_compressed}, {31'b0, c});
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        hq.delete();
        m_skip     = 1'b0;
        prev_stall = 1'b0;
        prev_flush = 1'b0;
    endtask

    // Turn the front of the halfword stream into whole instructions.
    task automatic model_parse();
        logic [47:0] a;
        logic [47:0] b;
        while (hq.size() > 0) begin
            a = hq[0];
            if (a[1:0] != 2'b11) begin
                exp_q.push_back({1'b1, a[47:16], 16'h0, a[15:0]});
                void'(hq.pop_front());
            end else if (hq.size() >= 2) begin
                b = hq[1];
                exp_q.push_back({1'b0, a[47:16], b[15:0], a[15:0]});
                void'(hq.pop_front());
                void'(hq.pop_front());
            end else begin
                break;
            end
        end
    endtask

    task automatic monitor();
        logic [64:0] e;
        logic [64:0] now;
        now = {bus_if.out_compressed, bus_if.out_pc, bus_if.out_instr};
        if (prev_stall && !prev_flush) begin
            chk("hold_valid", {31'b0, bus_if.out_valid}, 32'd1);
            chk("hold_instr", now[31:0],  held[31:0]);
            chk("hold_pc",    now[63:32], held[63:32]);
        end
        if (bus_if.out_valid && bus_if.out_ready) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected observed=%h expected=nothing", now);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_instr", now[31:0],  e[31:0]);
                chk("sb_pc",    now[63:32], e[63:32]);
                chk("sb_c",     {31'b0, now[64]}, {31'b0, e[64]});
            end
        end
        if (bus_if.fetch_valid && bus_if.fetch_ready) begin
            if (m_skip) m_skip = 1'b0;
            else        hq.push_back({bus_if.fetch_pc, bus_if.fetch_data[15:0]});
            hq.push_back({bus_if.fetch_pc + 32'd2, bus_if.fetch_data[31:16]});
            model_parse();
        end
        if (bus_if.flush) begin
            exp_q.delete();
            hq.delete();
            m_skip = bus_if.flush_pc[1];
        end
        prev_stall = bus_if.out_valid && !bus_if.out_ready;
        prev_flush = bus_if.flush;
        held       = now;
    endtask

    task automatic cycle();
        #1;
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fetch(input logic v, input logic [31:0] data, input logic [31:0] pc);
        bus_if.fetch_valid = v;
        bus_if.fetch_data  = data;
        bus_if.fetch_pc    = pc;
    endtask

    function automatic logic [15:0] rand_parcel();
        logic [15:0] p;
        p = 16'($urandom());
        if ($urandom_range(0, 1) == 1) p[1:0] = 2'b11;
        else                           p[1:0] = 2'($urandom_range(0, 2));
        return p;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'b0, bus_if.out_valid}, 32'd0);
        chk({tag, "_instr"}, bus_if.out_instr, 32'd0);
        chk({tag, "_pc"},    bus_if.out_pc,    32'd0);
        chk({tag, "_c"},     {31'b0, bus_if.out_compressed}, 32'd0);
    endtask

    logic [31:0] pc;
    logic        hs;
    logic        fl;

    initial begin
        rst              = 1'b1;
        bus_if.flush     = 1'b0;
        bus_if.flush_pc  = 32'h0;
        bus_if.out_ready = 1'b1;
        set_fetch(1'b0, 32'h0, 32'h0);
        model_reset();
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Two compressed parcels from one word.
        set_fetch(1'b1, 32'h4505_4501, 32'h100);
        #1;
        chk("t1_first_ready", {31'b0, bus_if.fetch_ready}, 32'd1);
        cycle();
        chk_out("t1_a", 1'b1, 32'h0000_4501, 32'h100, 1'b1);
        set_fetch(1'b0, 32'h0, 32'h0);
        #1;
        chk("t1_busy_ready", {31'b0, bus_if.fetch_ready}, 32'd0);
        cycle();
        chk_out("t1_b", 1'b1, 32'h0000_4505, 32'h102, 1'b1);
        cycle();
        chk_out("t1_idle", 1'b0, 32'h0, 32'h0, 1'b0);

        // 32-bit instruction straddling two words.
        set_fetch(1'b1, 32'h0513_4501, 32'h100);
        cycle();
        chk_out("t2_a", 1'b1, 32'h0000_4501, 32'h100, 1'b1);
        set_fetch(1'b1, 32'h4505_0000, 32'h104);
        #1;
        chk("t2_ready", {31'b0, bus_if.fetch_ready}, 32'd1);
        cycle();
        chk_out("t2_b", 1'b1, 32'h0000_0513, 32'h102, 1'b0);
        set_fetch(1'b0, 32'h0, 32'h0);
        cycle();
        chk_out("t2_c", 1'b1, 32'h0000_4505, 32'h106, 1'b1);
        cycle();
        chk_out("t2_idle", 1'b0, 32'h0, 32'h0, 1'b0);

        // Redirect onto an upper halfword; a concurrent fetch is ignored.
        bus_if.flush    = 1'b1;
        bus_if.flush_pc = 32'h202;
        set_fetch(1'b1, 32'hdead_beef, 32'h900);
        #1;
        chk("t3_flush_ready", {31'b0, bus_if.fetch_ready}, 32'd0);
        cycle();
        bus_if.flush = 1'b0;
        chk_out("t3_flush", 1'b0, 32'h0, 32'h0, 1'b0);
        set_fetch(1'b1, 32'h4505_1111, 32'h200);
        cycle();
        chk_out("t3_skip", 1'b0, 32'h0, 32'h0, 1'b0);
        set_fetch(1'b0, 32'h0, 32'h0);
        cycle();
        chk_out("t3_b", 1'b1, 32'h0000_4505, 32'h202, 1'b1);
        cycle();

        // Backpressure holds the output and blocks fetch.
        set_fetch(1'b1, 32'h00a0_0093, 32'h300);
        cycle();
        chk_out("t4_a", 1'b1, 32'h00a0_0093, 32'h300, 1'b0);
        bus_if.out_ready = 1'b0;
        set_fetch(1'b1, 32'h0010_8113, 32'h304);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_stall_ready", {31'b0, bus_if.fetch_ready}, 32'd0);
            cycle();
            chk_out("t4_hold", 1'b1, 32'h00a0_0093, 32'h300, 1'b0);
        end
        bus_if.out_ready = 1'b1;
        #1;
        chk("t4_release_ready", {31'b0, bus_if.fetch_ready}, 32'd1);
        cycle();
        chk_out("t4_b", 1'b1, 32'h0010_8113, 32'h304, 1'b0);
        set_fetch(1'b0, 32'h0, 32'h0);
        cycle();
        chk_out("t4_idle", 1'b0, 32'h0, 32'h0, 1'b0);

        // Flush while a residual and a stalled output are both live.
        bus_if.out_ready = 1'b0;
        set_fetch(1'b1, 32'h0513_4501, 32'h400);
        cycle();
        chk_out("t5_a", 1'b1, 32'h0000_4501, 32'h400, 1'b1);
        set_fetch(1'b0, 32'h0, 32'h0);
        bus_if.flush    = 1'b1;
        bus_if.flush_pc = 32'h500;
        cycle();
        bus_if.flush     = 1'b0;
        bus_if.out_ready = 1'b1;
        chk_out("t5_flush", 1'b0, 32'h0, 32'h0, 1'b0);
        set_fetch(1'b1, 32'h4505_4501, 32'h500);
        cycle();
        chk_out("t5_b", 1'b1, 32'h0000_4501, 32'h500, 1'b1);
        set_fetch(1'b0, 32'h0, 32'h0);
        cycle();
        chk_out("t5_c", 1'b1, 32'h0000_4505, 32'h502, 1'b1);
        cycle();
        chk_out("t5_idle", 1'b0, 32'h0, 32'h0, 1'b0);

        // Reset asserted between clock edges.
        set_fetch(1'b1, 32'h00a0_0093, 32'h600);
        cycle();
        chk_out("t6_pre", 1'b1, 32'h00a0_0093, 32'h600, 1'b0);
        set_fetch(1'b0, 32'h0, 32'h0);
        bus_if.out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("t6_async");
        model_reset();
        @(posedge clk);
        #1;
        rst              = 1'b0;
        bus_if.out_ready = 1'b1;
        set_fetch(1'b1, 32'h0000_0513, 32'h0);
        #1;
        chk("t6_ready", {31'b0, bus_if.fetch_ready}, 32'd1);
        cycle();
        chk_out("t6_b", 1'b1, 32'h0000_0513, 32'h0, 1'b0);
        set_fetch(1'b0, 32'h0, 32'h0);
        cycle();

        // Random traffic, starting near the top of the address space to exercise wrap.
        pc = 32'hFFFF_FFE0;
        for (int i = 0; i < 3000; i++) begin
            bus_if.flush = ($urandom_range(0, 49) == 0);
            if (bus_if.flush) bus_if.flush_pc = $urandom() & 32'hFFFF_FFFE;
            set_fetch($urandom_range(0, 9) < 7, {rand_parcel(), rand_parcel()}, pc);
            bus_if.out_ready = ($urandom_range(0, 9) < 7);
            #1;
            hs = bus_if.fetch_valid && bus_if.fetch_ready;
            fl = bus_if.flush;
            cycle();
            if (fl)      pc = bus_if.flush_pc & 32'hFFFF_FFFC;
            else if (hs) pc = pc + 32'd4;
        end

        bus_if.flush     = 1'b0;
        bus_if.out_ready = 1'b1;
        set_fetch(1'b0, 32'h0, 32'h0);
        repeat (6) cycle();
        chk("drain_pending", exp_q.size(), 32'd0);
        chk("drain_valid", {31'b0, bus_if.out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_instr_aligner.md
RISCV_INSTR_ALIGNER -- requirements
Module: riscv_instr_aligner

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: flush  in  1  synchronous pipeline redirect.
REQ-004 SHALL have: flush_pc  in  32  redirect target; bit 1 selects the upper-half start.
REQ-005 SHALL have: fetch_valid  in  1  fetch word valid.
REQ-006 SHALL have: fetch_ready  out  1  fetch word accepted this cycle when high with fetch_valid.
REQ-007 SHALL have: fetch_data  in  32  little-endian fetch word.
REQ-008 SHALL have: fetch_pc  in  32  word-aligned address of fetch_data.
REQ-009 SHALL have: out_valid  out  1  aligned instruction valid.
REQ-010 SHALL have: out_ready  in  1  decoder accepts out_instr.
REQ-011 SHALL have: out_instr  out  32  instruction; compressed parcels zero-extended to {16'h0, parcel}.
REQ-012 SHALL have: out_pc  out  32  instruction address.
REQ-013 SHALL have: out_compressed  out  1  out_instr[1:0] != 2'b11.

Function
REQ-014 SHALL hold state: residual halfword res_h[15:0], res_pc[31:0], res_v, skip_lo, and a one-entry output register (out_*).
REQ-015 SHALL define load = !out_valid || out_ready; the output register updates only when load is high.
REQ-016 SHALL drive fetch_ready = load && !flush && !(res_v && res_h[1:0] != 2'b11).
REQ-017 SHALL emit, with res_v and res_h compressed, {16'h0,res_h} at res_pc with out_compressed=1, then clear res_v; no fetch is consumed.
REQ-018 SHALL, with res_v, res_h 32-bit, and a fetch handshake, emit {fetch_data[15:0],res_h} at res_pc with out_compressed=0, then load res_h=fetch_data[31:16], res_pc=fetch_pc+2, res_v=1.
REQ-019 SHALL, with res_v, res_h 32-bit, and no fetch_valid, set out_valid=0 if load is high and keep the residual.
REQ-020 SHALL, with !res_v, skip_lo=1, and a handshake, discard fetch_data[15:0], load res_h=fetch_data[31:16], res_pc=fetch_pc+2, res_v=1, clear skip_lo, and emit nothing (out_valid=0).
REQ-021 SHALL, with !res_v, skip_lo=0, a handshake, and fetch_data[1:0]!=2'b11, emit the lower parcel compressed at fetch_pc and load the upper half into the residual at fetch_pc+2.
REQ-022 SHALL, with !res_v, skip_lo=0, a handshake, and fetch_data[1:0]==2'b11, emit fetch_data at fetch_pc, out_compressed=0, with res_v unchanged at 0.
REQ-023 SHALL set out_valid=0 on load when no case in REQ-017..022 emits.
REQ-024 SHALL have a latency of one cycle from fetch handshake to out_valid, and sustain one instruction per cycle under no backpressure.
REQ-025 SHALL hold out_instr, out_pc, and out_compressed stable while out_valid && !out_ready.
REQ-026 SHALL give flush priority over all events: next cycle res_v=0, out_valid=0, skip_lo=flush_pc[1]; any concurrent fetch_valid is ignored.
REQ-027 SHALL perform pc arithmetic modulo 2^32; no alignment check on fetch_pc.

Reset
REQ-028 SHALL, on rst asserted at any time, asynchronously clear res_v, skip_lo, out_valid, out_instr, out_pc, out_compressed, res_h, and res_pc to 0.
REQ-029 SHALL drive fetch_ready=1 in the first cycle after rst deasserts (res_v=0, out_valid=0).

Verification
REQ-030 SHALL verify two compressed parcels: fetch 32'h4505_4501 @0x100, out_ready=1 -> cycle+1: 32'h00004501 pc 0x100 c=1; cycle+2: 32'h00004505 pc 0x102 c=1; fetch_ready=0 during the second emission.
REQ-031 SHALL verify a straddling 32-bit instruction: words 32'h0513_4501 @0x100, 32'h4505_0000 @0x104 -> 0x00004501@0x100 c=1, 0x00000513@0x102 c=0, 0x00004505@0x106 c=1.
REQ-032 SHALL verify a misaligned redirect: flush, flush_pc=0x202, then word 32'h4505_1111 @0x200 -> no emission for 0x1111; 0x00004505@0x202 c=1.
REQ-033 SHALL verify backpressure: out_valid=1, out_ready=0 for 3 cycles -> outputs unchanged, fetch_ready=0; release -> next instruction follows in the next cycle.
REQ-034 SHALL verify flush mid-operation: res_v=1, out_valid=1, flush pulse -> next cycle out_valid=0, res_v=0, and the stale residual is never emitted.
REQ-035 SHALL verify rst asserted mid-stream between clock edges -> all outputs 0 immediately; after release, 32'h00000513 @0x0 is emitted one cycle after the handshake.
